// File: rtl/instr_encoder.sv
//==============================================================================
// Module   : instr_encoder
// Purpose  : Packs decoded instruction fields into 32-bit ARM-subset words and
//            writes them sequentially into instruction memory.
// Option   : INSTR_ENCODER_CHECK_EN flags and drops op class 11 bundles.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_encoder #(
    parameter int                DEPTH  = 64,
    parameter int                ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [1:0]                 in_op,
    input  logic                       in_i,
    input  logic                       in_l,
    input  logic [3:0]                 in_cmd,
    input  logic                       in_s,
    input  logic [3:0]                 in_cond,
    input  logic [3:0]                 in_rn,
    input  logic [3:0]                 in_rd,
    input  logic [11:0]                in_src2,
    input  logic [23:0]                in_imm24,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [31:0]                wr_data,
    output logic                       busy,
    output logic                       done,
    output logic                       full,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int                c_CW    = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0]   c_DEPTH = c_CW'(DEPTH);
    localparam logic [ADDR_W-1:0] c_STEP  = ADDR_W'(4);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCEPT = 2'd1;
    localparam logic [1:0] c_WRITE  = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_last;
    logic [c_CW-1:0]   r_count;
    logic              r_full;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_accept;
    logic              w_illegal;
    logic              w_start_ok;
    logic [c_CW-1:0]   w_count_inc;

    always_comb begin
        w_word = '0;
        case (in_op)
            2'b00:   w_word = {in_cond, 2'b00, in_i, in_cmd, in_s, in_rn, in_rd, in_src2};
            // Immediate offset, pre-index, add, word access, no writeback.
            2'b01:   w_word = {in_cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, in_l,
                               in_rn, in_rd, in_src2};
            2'b10:   w_word = {in_cond, 2'b10, 1'b1, 1'b0, in_imm24};
            default: w_word = {in_cond, 2'b11, in_i, in_cmd, in_s, in_rn, in_rd, in_src2};
        endcase
    end

`ifdef INSTR_ENCODER_CHECK_EN
    assign w_illegal = (in_op == 2'b11);
`else
    assign w_illegal = 1'b0;
`endif

    assign w_accept    = (r_state == c_ACCEPT) && in_valid;
    assign w_start_ok  = ((r_state == c_IDLE) || (r_state == c_DONE)) && start;
    assign w_count_inc = r_count + c_CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) w_state_nxt = c_ACCEPT;
            end
            c_ACCEPT: begin
                if (w_accept) begin
                    if (!w_illegal)  w_state_nxt = c_WRITE;
                    else if (in_last) w_state_nxt = c_DONE;
                end
            end
            c_WRITE: begin
                if (r_last || (w_count_inc == c_DEPTH)) w_state_nxt = c_DONE;
                else                                    w_state_nxt = c_ACCEPT;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_addr  <= BASE;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_addr  <= BASE;
                r_count <= '0;
                r_full  <= 1'b0;
                r_err   <= 1'b0;
            end
            if (w_accept) begin
                if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    r_data <= w_word;
                    r_last <= in_last;
                end
            end
            if (r_state == c_WRITE) begin
                r_addr  <= r_addr + c_STEP;
                r_count <= w_count_inc;
                if (w_count_inc == c_DEPTH) r_full <= 1'b1;
            end
        end
    end

    // Gated by reset so a WRITE interrupted by reset never reaches memory.
    assign wr_en    = (r_state == c_WRITE) && !reset;
    assign wr_addr  = r_addr;
    assign wr_data  = r_data;
    assign in_ready = (r_state == c_ACCEPT);
    assign busy     = (r_state == c_ACCEPT) || (r_state == c_WRITE);
    assign done     = (r_state == c_DONE);
    assign full     = r_full;
    assign err      = r_err;
    assign count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
//==============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder (DEPTH=4 build).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int c_DEPTH = 4;
    localparam int c_CW    = $clog2(c_DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [1:0]        in_op = '0;
    logic              in_i = 1'b0;
    logic              in_l = 1'b0;
    logic [3:0]        in_cmd = '0;
    logic              in_s = 1'b0;
    logic [3:0]        in_cond = '0;
    logic [3:0]        in_rn = '0;
    logic [3:0]        in_rd = '0;
    logic [11:0]       in_src2 = '0;
    logic [23:0]       in_imm24 = '0;
    logic              wr_en;
    logic [31:0]       wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              full;
    logic              err;
    logic [c_CW-1:0]   count;

    instr_encoder #(.DEPTH(c_DEPTH), .ADDR_W(32), .BASE(32'h0)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_op(in_op), .in_i(in_i), .in_l(in_l), .in_cmd(in_cmd), .in_s(in_s),
        .in_cond(in_cond), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
        .in_imm24(in_imm24), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .full(full), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        i, l, s, last;
        logic [3:0]  cmd, cond, rn, rd;
        logic [11:0] src2;
        logic [23:0] imm24;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[6];
    logic [63:0] wlog[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_write(input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wlog.size()) begin
            check($sformatf("waddr[%0d]", idx), wlog[idx][63:32], a);
            check($sformatf("wdata[%0d]", idx), wlog[idx][31:0], d);
        end else begin
            n_checks++;
            $display("FAIL wmissing[%0d]: got none expected %h@%h", idx, d, a);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wlog.push_back({wr_addr, wr_data});
            check("ready_with_wren", {31'b0, in_ready}, 32'h0);
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input vec_t v);
        bit ok = 1'b0;
        in_op = v.op; in_i = v.i; in_l = v.l; in_s = v.s; in_last = v.last;
        in_cmd = v.cmd; in_cond = v.cond; in_rn = v.rn; in_rd = v.rd;
        in_src2 = v.src2; in_imm24 = v.imm24;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL done_timeout: got done=0 expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_ready;
        //          op     i     l     s     last  cmd    cond   rn     rd     src2     imm24     exp
        tbl[0] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 4'hE, 4'h2, 4'h1, 12'h005, 24'h0,      32'hE2821005};
        tbl[1] = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 4'h4, 4'h3, 12'h008, 24'h0,      32'hE5943008};
        tbl[2] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hE, 4'h4, 4'h3, 12'h008, 24'h0,      32'hE5843008};
        tbl[3] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'hE, 4'h0, 4'h0, 12'h000, 24'h000002, 32'hEA000002};
        tbl[4] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 4'h0, 4'h6, 4'h5, 12'h007, 24'h0,      32'h00565007};
        tbl[5] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 4'h0, 12'h000, 24'h0,      32'hEC000000};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_wr_en",    {31'b0, wr_en},    32'h0);
        check("rst_wr_addr",  wr_addr,           32'h0);
        check("rst_wr_data",  wr_data,           32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h0);
        check("rst_flags",    {28'b0, busy, done, full, err}, 32'h0);
        check("rst_count",    32'(count),        32'h0);
        @(posedge clk); #1;

        // Single ADD with last: exact latency of write and done.
        wlog.delete();
        do_start();
        send(tbl[0]);
        @(negedge clk);
        check("t1_wren_cycle", {31'b0, wr_en}, 32'h1);
        check("t1_wdata_live", wr_data, 32'hE2821005);
        @(negedge clk);
        check("t1_done",  {31'b0, done}, 32'h1);
        check("t1_count", 32'(count), 32'h1);
        check("t1_busy",  {31'b0, busy}, 32'h0);
        check("t1_nwr",   32'(wlog.size()), 32'h1);
        check_write(0, 32'h0, 32'hE2821005);

        // Table-driven sequence: LDR, STR, B(last).
        @(posedge clk); #1;
        wlog.delete();
        do_start();
        check("t2_done_clr", {31'b0, done}, 32'h0);
        for (int v = 1; v <= 3; v++) send(tbl[v]);
        wait_done();
        for (int v = 1; v <= 3; v++) check_write(v - 1, 32'((v - 1) * 4), tbl[v].exp);
        check("t2_count", 32'(count), 32'h3);
        check("t2_full",  {31'b0, full}, 32'h0);

        // DEPTH reached without last; fifth bundle must be refused.
        @(posedge clk); #1;
        wlog.delete();
        do_start();
        for (int v = 0; v < 4; v++) send(tbl[4]);
        in_op = 2'b00; in_valid = 1'b1;
        seen_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) seen_ready = 1'b1;
        end
        in_valid = 1'b0;
        check("t3_no_fifth", {31'b0, seen_ready}, 32'h0);
        check("t3_full",  {31'b0, full}, 32'h1);
        check("t3_done",  {31'b0, done}, 32'h1);
        check("t3_count", 32'(count), 32'h4);
        check("t3_nwr",   32'(wlog.size()), 32'h4);
        for (int v = 0; v < 4; v++) check_write(v, 32'(v * 4), 32'h00565007);

        // op 11 followed by ADD(last).
        @(posedge clk); #1;
        wlog.delete();
        do_start();
        check("t4_full_clr", {31'b0, full}, 32'h0);
        send(tbl[5]);
        send(tbl[0]);
        wait_done();
`ifdef INSTR_ENCODER_CHECK_EN
        check("t4_err",   {31'b0, err}, 32'h1);
        check("t4_nwr",   32'(wlog.size()), 32'h1);
        check("t4_count", 32'(count), 32'h1);
        check_write(0, 32'h0, 32'hE2821005);
`else
        check("t4_err",   {31'b0, err}, 32'h0);
        check("t4_nwr",   32'(wlog.size()), 32'h2);
        check("t4_count", 32'(count), 32'h2);
        check_write(0, 32'h0, tbl[5].exp);
        check_write(1, 32'h4, 32'hE2821005);
`endif

        // Reset asserted during the WRITE cycle.
        @(posedge clk); #1;
        wlog.delete();
        do_start();
        send(tbl[4]);
        reset = 1'b1;
        @(negedge clk);
        check("t5_wren_blocked", {31'b0, wr_en}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_flags", {27'b0, in_ready, busy, done, full, err}, 32'h0);
        check("t5_count", 32'(count), 32'h0);
        check("t5_addr",  wr_addr, 32'h0);
        check("t5_data",  wr_data, 32'h0);
        check("t5_nwr",   32'(wlog.size()), 32'h0);
        @(posedge clk); #1;
        do_start();
        send(tbl[0]);
        wait_done();
        check_write(0, 32'h0, 32'hE2821005);

        // start pulses mid-session are ignored.
        @(posedge clk); #1;
        wlog.delete();
        do_start();
        send(tbl[1]);
        start = 1'b1;
        @(posedge clk); #1;
        send(tbl[2]);
        start = 1'b0;
        send(tbl[3]);
        wait_done();
        check("t6_count", 32'(count), 32'h3);
        for (int v = 1; v <= 3; v++) check_write(v - 1, 32'((v - 1) * 4), tbl[v].exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Field-level instruction encoder and instruction-memory loader for the single-cycle ARM-subset core. It accepts one decoded instruction per handshake as separate fields: op class, immediate/load flags, command, registers, operand and condition. It packs those fields into the 32-bit word layout that the core's main decoder consumes, then writes the words sequentially into instruction memory. It sits between the test/boot host and the instruction memory write port, and is the producing end of the instruction encoding the datapath decodes.

## Interface
- DEPTH, 64: maximum words written per load session.
- ADDR_W, 32: width of wr_addr (byte address).
- BASE, 0: byte address of the first word written after start.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session at BASE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder accepts bundle this cycle.
- in_last  in  1  bundle is final instruction of session.
- in_op  in  2  op class: 00 data-processing, 01 memory, 10 branch, 11 unimplemented.
- in_i  in  1  data-processing immediate flag (word bit 25).
- in_l  in  1  memory load flag (1 LDR, 0 STR; word bit 20).
- in_cmd  in  4  data-processing command (bits 24:21).
- in_s  in  1  data-processing set-flags (bit 20).
- in_cond  in  4  condition (bits 31:28).
- in_rn, in_rd  in  4 each  register fields (bits 19:16, 15:12).
- in_src2  in  12  operand2 / memory offset (bits 11:0).
- in_imm24  in  24  branch offset (bits 23:0).
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_W  byte address, word aligned.
- wr_data  out  32  encoded instruction.
- busy  out  1  session active.
- done  out  1  session finished; held until next start.
- full  out  1  session ended by reaching DEPTH.
- err  out  1  sticky; illegal bundle seen this session.
- count  out  $clog2(DEPTH+1)  words written this session.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: in_ready=0. start -> ACCEPT; clears count, full, err, done; sets address to BASE.
- ACCEPT: in_ready=1. The handshake in_valid&in_ready registers the encoded word and in_last, then the state goes to WRITE.
- WRITE: wr_en=1 for exactly one cycle with wr_addr and wr_data. Then address += 4 and count += 1.
  - If the bundle was last, or count reaches DEPTH: go to DONE. full=1 in the DEPTH case.
  - Otherwise: go back to ACCEPT.
- DONE: done=1. start -> ACCEPT (new session as above).
- start outside IDLE/DONE is ignored.
- Encoding, with cond always in bits 31:28 and op in bits 27:26:
  - 00: {cond,00,in_i,in_cmd,in_s,rn,rd,src2}.
  - 01: {cond,01,0,1,1,0,0,in_l,rn,rd,src2}. This is an immediate offset with pre-index, add, word access and no writeback.
  - 10: {cond,10,1,0,imm24}.
- Address arithmetic is modulo 2^ADDR_W. Overflow wraps silently.
- busy=1 in ACCEPT and WRITE.
- Reset values: state IDLE; wr_en 0; wr_addr BASE; wr_data 0; in_ready, busy, done, full, err all 0; count 0.
- Reset mid-session aborts immediately. A WRITE in progress during the reset cycle is not issued.

## Timing
- Bundle accepted at edge N -> wr_en high during cycle N+1 -> in_ready high again at N+2.
- Throughput is one word per 2 cycles.
- wr_data and wr_addr are registered and stable while wr_en=1.
- done rises the cycle after the final WRITE cycle.
- in_ready is never high in the same cycle as wr_en.

## Configuration
- INSTR_ENCODER_CHECK_EN defined:
  - An accepted bundle with in_op=11 sets err.
  - That bundle is consumed but not written; count and address are unchanged and the state stays in ACCEPT.
  - If the bundle also had in_last set, the state goes to DONE.
- INSTR_ENCODER_CHECK_EN undefined:
  - in_op=11 is encoded as {cond,11,in_i,in_cmd,in_s,rn,rd,src2} and written normally.
  - err is tied 0.

## Test plan
- start; ADD R1,R2,#5 (op 00, i 1, cmd 0100, s 0, cond E, rn 2, rd 1, src2 005) with in_last -> one write 0xE2821005 at address 0; count=1; done=1 next cycle.
- Three bundles: LDR R3,[R4,#8], STR R3,[R4,#8], B imm24 0x000002 (last) -> writes 0xE5943008@0, 0xE5843008@4, 0xEA000002@8; count=3.
- DEPTH=4, five valid bundles, none with last -> four writes at 0,4,8,12; full=1; fifth bundle never accepted (in_ready=0).
- With CHECK_EN: bundle with op 11, then ADD with last -> err=1; only 0xE2821005 written, at address 0.
- reset asserted in the WRITE cycle -> no wr_en; all outputs at reset values next cycle; a fresh start writes from BASE.
- in_valid held high with a new start pulse arriving mid-session -> start ignored; addresses continue contiguously.
